// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_ctrl_pkg;

    localparam int MD_W = 32;

    typedef enum logic [1:0] {
        EXE_MD_MULT  = 2'd0,
        EXE_MD_MULTU = 2'd1,
        EXE_MD_DIV   = 2'd2,
        EXE_MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

    // Request captured when an operation is accepted; sa/sb are operand sign bits.
    typedef struct packed {
        md_op_e          op;
        logic [MD_W-1:0] a;
        logic [MD_W-1:0] b;
        logic            sa;
        logic            sb;
    } md_req_t;

    function automatic logic op_signed(md_op_e op);
        return (op == EXE_MD_MULT) || (op == EXE_MD_DIV);
    endfunction

    function automatic logic op_div(md_op_e op);
        return op[1];
    endfunction

    function automatic logic [MD_W-1:0] mag(logic [MD_W-1:0] v, logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side bundle of the multiply/divide unit: op request, MTHI/MTLO, status and HI/LO.
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, cancel, hi_we, lo_we, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, cancel, hi_we, lo_we, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl_core.sv
// One radix-2 iteration per enable: shift-add multiply or restoring shift-subtract divide.
// acc holds the product (multiply) or the partial remainder in acc[2W-1:W] (divide);
// q shifts multiplier bits out (multiply) or dividend bits out / quotient bits in (divide).
module muldiv_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         is_div,
    input  logic [W-1:0] ld_m,
    input  logic [W-1:0] ld_q,
    output logic [2*W-1:0] acc,
    output logic [W-1:0] q
);
    logic [W-1:0] m;
    logic [W:0]   sum;
    logic [W:0]   shl;
    logic [W:0]   diff;
    logic         ge;

    // 33-bit add keeps the carry; 33-bit compare/subtract on the shifted remainder.
    always_comb begin
        sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (q[0] ? m : {W{1'b0}})};
        shl  = {acc[2*W-1:W], q[W-1]};
        ge   = (shl >= {1'b0, m});
        diff = shl - {1'b0, m};
    end

    // Operand load, then one iteration per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            q   <= '0;
            m   <= '0;
        end else if (load) begin
            acc <= '0;
            q   <= ld_q;
            m   <= ld_m;
        end else if (en) begin
            if (is_div) begin
                acc[2*W-1:W] <= ge ? diff[W-1:0] : shl[W-1:0];
                q            <= {q[W-2:0], ge};
            end else begin
                acc <= {sum, acc[W-1:1]};
                q   <= {1'b0, q[W-1:1]};
            end
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, sign fix-up and the HI/LO registers.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int ITER = MD_W
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(ITER);

    md_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt;
    md_req_t          req;
    logic             accept, core_load, core_en, fin;
    logic             sgn, is_div, neg_res;
    logic [63:0]      acc, prod;
    logic [31:0]      cq, quo, rem, res_hi, res_lo;
    logic [31:0]      hi_q, lo_q;
    logic             done_q;

    assign sgn     = op_signed(req.op);
    assign is_div  = op_div(req.op);
    assign neg_res = sgn && (req.sa ^ req.sb);

    muldiv_core #(.W(MD_W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .en     (core_en),
        .is_div (is_div),
        .ld_m   (is_div ? mag(req.b, sgn && req.sb) : mag(req.a, sgn && req.sa)),
        .ld_q   (is_div ? mag(req.a, sgn && req.sa) : mag(req.b, sgn && req.sb)),
        .acc    (acc),
        .q      (cq)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state and per-state strobes; cancel pre-empts every busy state.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        core_load = 1'b0;
        core_en   = 1'b0;
        fin       = 1'b0;
        case (state)
            S_IDLE: if (bus.start && !bus.cancel) begin
                accept   = 1'b1;
                state_nx = S_PREP;
            end
            S_PREP: begin
                core_load = 1'b1;
                state_nx  = S_CALC;
            end
            S_CALC: begin
                core_en = 1'b1;
                if (cnt == CNT_W'(ITER - 1)) state_nx = S_FIX;
            end
            S_FIX: begin
                fin      = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (state != S_IDLE && bus.cancel) begin
            state_nx  = S_IDLE;
            core_load = 1'b0;
            core_en   = 1'b0;
            fin       = 1'b0;
        end
    end

    // Sign fix-up of the magnitude result; divide-by-zero returns all-ones / raw dividend.
    always_comb begin
        prod = neg_res ? (~acc + 64'd1) : acc;
        quo  = neg_res ? (~cq + 32'd1) : cq;
        rem  = (sgn && req.sa) ? (~acc[63:32] + 32'd1) : acc[63:32];
        if (!is_div) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (req.b == '0) begin
            res_hi = req.a;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // Request latch, counter, HI/LO and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            req    <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            if (accept)
                req <= '{op: md_op_e'(bus.op), a: bus.a, b: bus.b, sa: bus.a[31], sb: bus.b[31]};
            if (core_load)    cnt <= '0;
            else if (core_en) cnt <= cnt + 1'b1;
            if (fin) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == S_IDLE) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: results, latency, cancel/reset aborts and MTHI/MTLO rules.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] lo_t0;

    muldiv_ctrl_if bus();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for it to finish, check latency, done pulse and HI/LO.
    // poke re-asserts start (with other operands) mid-operation.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit poke);
        int cyc;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        lo_t0 = bus.lo;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            bus.start = poke && (cyc == 5);
            if (poke) begin
                bus.op = EXE_MD_MULTU; bus.a = 32'd5; bus.b = 32'd5;
            end
            tick();
        end
        bus.start = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'd34);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_hi"}, bus.hi, exp_hi);
        chk({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        int dn;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cancel = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        // MTLO in the same cycle as start lands first, result overwrites it later.
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_A5A5;
        run_op("multu_max", EXE_MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        chk("mtlo_with_start", lo_t0, 32'h0000_A5A5);

        // Back-to-back from the done cycle; spurious start mid-op.
        run_op("mult_neg", EXE_MD_MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        tick();
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        run_op("div_neg", EXE_MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", EXE_MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", EXE_MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0);
        run_op("divu_100_7", EXE_MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        tick();

        // Cancel at CALC iteration 10; MTHI while busy is dropped.
        bus.start = 1'b1; bus.op = EXE_MD_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        tick();
        bus.hi_we = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("cancel_pre_busy", {31'd0, bus.busy}, 32'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dn++;
            tick();
        end
        chk("cancel_no_done", 32'(dn), 32'd0);
        chk("cancel_hi", bus.hi, 32'd2);
        chk("cancel_lo", bus.lo, 32'd14);

        // Reset mid-operation.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);

        // MTHI in IDLE.
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        tick();
        bus.hi_we = 1'b0;
        chk("mthi_idle_hi", bus.hi, 32'h0000_1234);
        chk("mthi_idle_lo", bus.lo, 32'd0);

        // start with cancel in IDLE is ignored.
        bus.start = 1'b1; bus.cancel = 1'b1;
        tick();
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("start_cancel_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("start_cancel_busy2", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
